// File: rtl/tsqr_stim_harness_if.sv
// rtl/tsqr_stim_harness_if.sv - core-facing stimulus and DMA readback bundle
//
// Purpose: groups the signals that run between the stimulus harness and the
// TSQR core. The member names are the core's own port names.
// Members:
//   e_val          e-value for the current input beat
//   vec_ready      beat strobe (pg_ready, ug_ready and all e_*_ready)
//   pg_i, ug_i     P-group and U-group input vectors
//   dma_mem_enb    DMA read enable, all three bits equal
//   dma_mem_addrb  DMA read address
//   dma_mem_doutb  DMA read data, valid one cycle after the address
//   tsqr_fi        core finish level
//   mx_cnt         core max counter
// Modports: master = harness side, slave = core side.
interface tsqr_stim_harness_if #(
  parameter int VEC_W  = 16384,
  parameter int E_W    = 32,
  parameter int ADDR_W = 8
);
  logic [E_W-1:0]    e_val;
  logic              vec_ready;
  logic [VEC_W-1:0]  pg_i;
  logic [VEC_W-1:0]  ug_i;
  logic [2:0]        dma_mem_enb;
  logic [ADDR_W-1:0] dma_mem_addrb;
  logic [VEC_W-1:0]  dma_mem_doutb;
  logic              tsqr_fi;
  logic [15:0]       mx_cnt;

  modport master (
    output e_val, vec_ready, pg_i, ug_i, dma_mem_enb, dma_mem_addrb,
    input  dma_mem_doutb, tsqr_fi, mx_cnt
  );

  modport slave (
    input  e_val, vec_ready, pg_i, ug_i, dma_mem_enb, dma_mem_addrb,
    output dma_mem_doutb, tsqr_fi, mx_cnt
  );
endinterface

// File: rtl/tsqr_stim_harness.sv
// rtl/tsqr_stim_harness.sv - sequenced stimulus/readback harness for the TSQR core
//
// Purpose: per tile, streams N_VEC pseudo-random beats into the core, waits
// for the core finish (bounded by TIMEOUT), sweeps DEPTH DMA words and folds
// them into a 32-bit rotating XOR signature. Runs N_TILES tiles per start.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          run request, sampled only while idle
//   busy           high in every state except IDLE
//   done           one-cycle pulse at run end
//   err_timeout    sticky finish-timeout flag, cleared on accepted start
//   signature      running readback signature
//   tile_no        current tile index
//   mx_cnt_last    mx_cnt captured at each tile's finish
//   core           core-facing bundle (master side)
module tsqr_stim_harness #(
  parameter int          VEC_W   = 16384,
  parameter int          E_W     = 32,
  parameter int          TILE_W  = 16,
  parameter int          ADDR_W  = 8,
  parameter int          DEPTH   = 256,
  parameter int          N_VEC   = 16,
  parameter int          N_TILES = 4,
  parameter int          TIMEOUT = 65535,
  parameter logic [31:0] SEED    = 32'hACE1_0001
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                err_timeout,
  output logic [31:0]         signature,
  output logic [TILE_W-1:0]   tile_no,
  output logic [15:0]         mx_cnt_last,
  tsqr_stim_harness_if.master core
);
  localparam int REP = VEC_W / 32;

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_FI, READ, DRAIN, NEXT, FIN} state_t;

  state_t            state, state_nxt;
  logic [31:0]       lfsr, lfsr_nxt;
  logic [15:0]       beat;
  logic [31:0]       wait_cnt;
  logic [ADDR_W-1:0] addr;
  logic              rd_q;
  logic [31:0]       fold;
  logic              start_ok, fi_ok, timeout_hit;
  logic              last_beat, last_addr, last_tile;

  assign last_beat = (beat == 16'(N_VEC - 1));
  assign last_addr = (addr == ADDR_W'(DEPTH - 1));
  assign last_tile = (tile_no == TILE_W'(N_TILES - 1));

  // Galois form of x^32+x^22+x^2+x+1: shift right, toggle taps on carry-out.
  assign lfsr_nxt = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);

  always_comb begin
    fold = '0;
    for (int i = 0; i < REP; i++) fold = fold ^ core.dma_mem_doutb[i*32 +: 32];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_ok    = 1'b0;
    fi_ok       = 1'b0;
    timeout_hit = 1'b0;
    busy        = (state != IDLE);
    done        = (state == FIN);
    unique case (state)
      IDLE:    if (start) begin start_ok = 1'b1; state_nxt = LOAD; end
      LOAD:    if (last_beat) state_nxt = WAIT_FI;
      WAIT_FI: begin
        // A finish already high on entry is taken on the first cycle here.
        if (core.tsqr_fi) begin
          fi_ok     = 1'b1;
          state_nxt = READ;
        end else if (wait_cnt == 32'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_nxt   = FIN;
        end
      end
      READ:    if (last_addr) state_nxt = DRAIN;
      DRAIN:   state_nxt = NEXT;
      NEXT:    state_nxt = last_tile ? FIN : LOAD;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign core.vec_ready     = (state == LOAD);
  assign core.pg_i          = (state == LOAD) ? {REP{lfsr}} : '0;
  assign core.ug_i          = (state == LOAD) ? ~{REP{lfsr}} : '0;
  assign core.e_val         = (state == LOAD) ? E_W'({tile_no, beat}) : '0;
  assign core.dma_mem_enb   = (state == READ) ? 3'b111 : 3'b000;
  assign core.dma_mem_addrb = (state == READ) ? addr : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr        <= SEED;
      beat        <= '0;
      wait_cnt    <= '0;
      addr        <= '0;
      rd_q        <= 1'b0;
      tile_no     <= '0;
      signature   <= '0;
      err_timeout <= 1'b0;
      mx_cnt_last <= '0;
    end else begin
      beat     <= (state == LOAD && !last_beat) ? beat + 16'd1 : '0;
      wait_cnt <= (state == WAIT_FI) ? wait_cnt + 32'd1 : '0;
      addr     <= (state == READ && !last_addr) ? addr + ADDR_W'(1) : '0;
      // Read data lands one cycle after its address, so fold on the cycle
      // after an enabled read; DRAIN exists to catch the last word.
      rd_q     <= (state == READ);
      if (rd_q) signature <= {signature[30:0], signature[31]} ^ fold;
      if (state == LOAD) lfsr <= lfsr_nxt;
      if (fi_ok) mx_cnt_last <= core.mx_cnt;
      if (timeout_hit) err_timeout <= 1'b1;
      if (state == NEXT && !last_tile) tile_no <= tile_no + TILE_W'(1);
      if (start_ok) begin
        tile_no     <= '0;
        signature   <= '0;
        err_timeout <= 1'b0;
        lfsr        <= SEED;
      end
    end
  end
endmodule
